// File: rtl/cart_mbc_pkg.sv
// Shared definitions for the cartridge MBC: controller codes, bus region bounds,
// magic values and the default ROM image generator.
package cart_mbc_pkg;

  localparam int MBC_NONE = 0;
  localparam int MBC1     = 1;
  localparam int MBC5     = 5;

  localparam logic [15:0] ROM0_LO   = 16'h0000;
  localparam logic [15:0] ROMX_LO   = 16'h4000;
  localparam logic [15:0] ROMX_HI   = 16'h7FFF;
  localparam logic [15:0] EXTRAM_LO = 16'hA000;
  localparam logic [15:0] EXTRAM_HI = 16'hBFFF;

  localparam logic [3:0] RAM_MAGIC = 4'hA;
  localparam logic [7:0] OPEN_BUS  = 8'hFF;

  typedef struct packed {
    logic       ram_en;
    logic [8:0] rom_bank;
    logic [3:0] bank2;
    logic       mode;
  } mbc_regs_t;

  // Default cartridge image, a pure function of the 23-bit byte address so the
  // block needs no external file; every 16 KiB bank reads differently.
  function automatic logic [7:0] rom_image(input logic [22:0] a);
    logic [7:0] mid;
    logic [7:0] hi;
    mid = a[15:8];
    hi  = {1'b0, a[22:16]};
    return a[7:0] + {mid[6:0], 1'b0} + mid + {hi[4:0], 3'b000} - hi;
  endfunction

endpackage

// File: rtl/cart_mbc_regs.sv
// Bank control registers (ram_en, rom_bank, bank2/ram_bank, mode) and the
// ROM/RAM bank-index computation for the selected controller type.
module cart_mbc_regs
  import cart_mbc_pkg::*;
#(
  parameter int MBC_TYPE  = 1,
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] addr_sel,
  input  logic [7:0] data_w,
  input  logic       reg_write,
  output logic [8:0] rom0_bank,
  output logic [8:0] romx_bank,
  output logic [3:0] ram_bank,
  output logic       ram_ok
);

  localparam logic [8:0] ROM_MASK = 9'(ROM_BANKS - 1);
  localparam logic [3:0] RAM_MASK = (RAM_BANKS == 0) ? 4'd0 : 4'(RAM_BANKS - 1);

  mbc_regs_t  regs;
  logic [8:0] rom0_raw;
  logic [8:0] romx_raw;
  logic [3:0] ram_raw;

  // addr_sel is addr[14:12]: [2:1] picks the 8 KiB register window, [0]
  // splits the MBC5 rom_bank window into low byte and bit 8.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs.ram_en   <= 1'b0;
      regs.rom_bank <= 9'd1;
      regs.bank2    <= 4'd0;
      regs.mode     <= 1'b0;
    end else if (reg_write && MBC_TYPE != MBC_NONE) begin
      case (addr_sel[2:1])
        2'b00: regs.ram_en <= (data_w[3:0] == RAM_MAGIC);
        2'b01: begin
          if (MBC_TYPE == MBC5) begin
            if (addr_sel[0]) regs.rom_bank[8] <= data_w[0];
            else             regs.rom_bank[7:0] <= data_w;
          end else begin
            regs.rom_bank <= {4'd0, (data_w[4:0] == 5'd0) ? 5'd1 : data_w[4:0]};
          end
        end
        2'b10: regs.bank2 <= (MBC_TYPE == MBC5) ? data_w[3:0] : {2'b00, data_w[1:0]};
        default: begin
          if (MBC_TYPE != MBC5) regs.mode <= data_w[0];
        end
      endcase
    end
  end

  always_comb begin
    rom0_raw = 9'd0;
    romx_raw = 9'd1;
    ram_raw  = 4'd0;
    if (MBC_TYPE == MBC5) begin
      romx_raw = regs.rom_bank;
      ram_raw  = regs.bank2;
    end else if (MBC_TYPE != MBC_NONE) begin
      romx_raw = {2'b00, regs.bank2[1:0], regs.rom_bank[4:0]};
      if (regs.mode) begin
        rom0_raw = {2'b00, regs.bank2[1:0], 5'd0};
        ram_raw  = regs.bank2;
      end
    end
  end

  assign rom0_bank = rom0_raw & ROM_MASK;
  assign romx_bank = romx_raw & ROM_MASK;
  assign ram_bank  = ram_raw & RAM_MASK;
  assign ram_ok    = regs.ram_en && (RAM_BANKS != 0);

endmodule

// File: rtl/cart_mbc.sv
// Cartridge with memory bank controller on the CPU bus: ROM image, banked
// external RAM, address decode and the half-cycle registered read port.
module cart_mbc
  import cart_mbc_pkg::*;
#(
  parameter int MBC_TYPE  = 1,
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  output logic [7:0]  data_r,
  input  logic [7:0]  data_w,
  input  logic        write_enable,
  output logic        data_active
);

  localparam int RAM_DEPTH = ((RAM_BANKS == 0) ? 1 : RAM_BANKS) * 8192;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  logic              in_rom;
  logic              in_ram;
  logic [8:0]        rom0_bank;
  logic [8:0]        romx_bank;
  logic [8:0]        rom_sel;
  logic [3:0]        ram_bank;
  logic              ram_ok;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram [RAM_DEPTH];

  assign in_rom      = (addr <= ROMX_HI);
  assign in_ram      = (addr >= EXTRAM_LO) && (addr <= EXTRAM_HI);
  assign data_active = !write_enable && (in_rom || in_ram);

  cart_mbc_regs #(
    .MBC_TYPE (MBC_TYPE),
    .ROM_BANKS(ROM_BANKS),
    .RAM_BANKS(RAM_BANKS)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .addr_sel (addr[14:12]),
    .data_w   (data_w),
    .reg_write(write_enable && in_rom),
    .rom0_bank(rom0_bank),
    .romx_bank(romx_bank),
    .ram_bank (ram_bank),
    .ram_ok   (ram_ok)
  );

  assign rom_sel  = addr[14] ? romx_bank : rom0_bank;
  assign ram_addr = RAM_AW'({ram_bank, addr[12:0]});

  // RAM contents survive reset, like a battery-backed cartridge.
  always_ff @(posedge clk) begin
    if (!reset && write_enable && in_ram && ram_ok) ram[ram_addr] <= data_w;
  end

  always_ff @(negedge clk) begin
    if (reset)                data_r <= OPEN_BUS;
    else if (in_rom)          data_r <= rom_image({rom_sel, addr[13:0]});
    else if (in_ram && ram_ok) data_r <= ram[ram_addr];
    else                      data_r <= OPEN_BUS;
  end

endmodule

// File: tb/tb_cart_mbc.sv
// Bench for cart_mbc: four configurations on one shared bus, a reference model
// of the bank rules, and a scoreboard checked on every active read.
module tb_cart_mbc;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            we = 1'b0;
  logic [15:0]     addr = 16'h0000;
  logic [7:0]      data_w = 8'h00;
  logic [3:0][7:0] dr;
  logic [3:0]      da;

  int n_vec = 0;
  int n_err = 0;
  logic [51:0] exp_q[$];

  // per-instance configuration: MBC type, ROM banks, RAM banks
  int typ[4]   = '{1, 5, 5, 0};
  int rom_n[4] = '{64, 512, 64, 2};
  int ram_n[4] = '{4, 16, 0, 1};

  int m_ram_en[4];
  int m_rom_bank[4];
  int m_bank2[4];
  int m_mode[4];
  logic [7:0] m_ram[int];

  always #5 clk = ~clk;

  cart_mbc #(.MBC_TYPE(1), .ROM_BANKS(64), .RAM_BANKS(4)) u_mbc1 (
    .clk(clk), .reset(reset), .addr(addr), .data_r(dr[0]), .data_w(data_w),
    .write_enable(we), .data_active(da[0]));
  cart_mbc #(.MBC_TYPE(5), .ROM_BANKS(512), .RAM_BANKS(16)) u_mbc5 (
    .clk(clk), .reset(reset), .addr(addr), .data_r(dr[1]), .data_w(data_w),
    .write_enable(we), .data_active(da[1]));
  cart_mbc #(.MBC_TYPE(5), .ROM_BANKS(64), .RAM_BANKS(0)) u_mbc5_small (
    .clk(clk), .reset(reset), .addr(addr), .data_r(dr[2]), .data_w(data_w),
    .write_enable(we), .data_active(da[2]));
  cart_mbc #(.MBC_TYPE(0), .ROM_BANKS(2), .RAM_BANKS(1)) u_flat (
    .clk(clk), .reset(reset), .addr(addr), .data_r(dr[3]), .data_w(data_w),
    .write_enable(we), .data_active(da[3]));

  // ---------------- reference model ----------------
  function automatic int image(int a);
    return ((a & 255) + 3 * ((a >> 8) & 255) + 7 * ((a >> 16) & 127)) & 255;
  endfunction

  function automatic int ram_key(int d, int a);
    int bank;
    bank = 0;
    if (typ[d] == 1 && m_mode[d] != 0) bank = m_bank2[d];
    if (typ[d] == 5) bank = m_bank2[d];
    bank = bank % ram_n[d];
    return d * (1 << 20) + bank * 8192 + (a % 8192);
  endfunction

  // {care, byte}; care=0 for RAM bytes never written
  function automatic logic [8:0] expect_read(int d, int a);
    int b;
    int k;
    if (a < 'h8000) begin
      if (a < 'h4000) b = (typ[d] == 1 && m_mode[d] != 0) ? m_bank2[d] * 32 : 0;
      else if (typ[d] == 1) b = m_bank2[d] * 32 + m_rom_bank[d];
      else if (typ[d] == 5) b = m_rom_bank[d];
      else b = 1;
      b = b % rom_n[d];
      return {1'b1, 8'(image(b * 16384 + (a % 16384)))};
    end
    if (a >= 'hA000 && a <= 'hBFFF) begin
      if (m_ram_en[d] == 0 || ram_n[d] == 0) return {1'b1, 8'hFF};
      k = ram_key(d, a);
      if (m_ram.exists(k)) return {1'b1, m_ram[k]};
      return 9'h000;
    end
    return {1'b1, 8'hFF};
  endfunction

  function automatic void model_write(int d, int a, int v);
    if (a < 'h2000) begin
      if (typ[d] != 0) m_ram_en[d] = ((v & 15) == 10) ? 1 : 0;
    end else if (a < 'h4000) begin
      if (typ[d] == 1) m_rom_bank[d] = ((v & 31) == 0) ? 1 : (v & 31);
      else if (typ[d] == 5 && a < 'h3000) m_rom_bank[d] = (m_rom_bank[d] & 256) | (v & 255);
      else if (typ[d] == 5) m_rom_bank[d] = (m_rom_bank[d] & 255) | ((v & 1) << 8);
    end else if (a < 'h6000) begin
      if (typ[d] == 1) m_bank2[d] = v & 3;
      else if (typ[d] == 5) m_bank2[d] = v & 15;
    end else if (a < 'h8000) begin
      if (typ[d] == 1) m_mode[d] = v & 1;
    end else if (a >= 'hA000 && a <= 'hBFFF && m_ram_en[d] != 0 && ram_n[d] != 0) begin
      m_ram[ram_key(d, a)] = 8'(v);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      m_ram_en[d] = 0;
      m_rom_bank[d] = 1;
      m_bank2[d] = 0;
      m_mode[d] = 0;
    end
  endfunction

  function automatic logic bus_active(int a, logic w);
    return !w && (a <= 'h7FFF || (a >= 'hA000 && a <= 'hBFFF));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_expect(int a);
    logic [51:0] e;
    e = {16'(a), expect_read(3, a), expect_read(2, a), expect_read(1, a), expect_read(0, a)};
    exp_q.push_back(e);
  endtask

  task automatic check_active(int a, logic w);
    logic ea;
    ea = bus_active(a, w);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (da[d] !== ea) begin
        n_err++;
        $display("FAIL data_active dut%0d addr=%h we=%b got=%b exp=%b", d, a[15:0], w, da[d], ea);
      end
    end
  endtask

  task automatic do_read(int a);
    @(posedge clk);
    #1;
    reset = 1'b0;
    we = 1'b0;
    addr = 16'(a);
    data_w = 8'($urandom);
    if (bus_active(a, 1'b0)) push_expect(a);
    check_active(a, 1'b0);
  endtask

  task automatic do_write(int a, int v);
    @(posedge clk);
    #1;
    reset = 1'b0;
    we = 1'b1;
    addr = 16'(a);
    data_w = 8'(v);
    for (int d = 0; d < 4; d++) model_write(d, a, v);
    check_active(a, 1'b1);
  endtask

  // reset wins over a simultaneous write; reads in a reset cycle return 8'hFF
  task automatic do_reset(int a, logic w, int v);
    logic [51:0] e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    we = w;
    addr = 16'(a);
    data_w = 8'(v);
    model_reset();
    if (bus_active(a, w)) begin
      e = {16'(a), 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
      exp_q.push_back(e);
    end
  endtask

  function automatic int rand_ram_addr();
    return 'hA000 + $urandom_range(0, 31) + ($urandom_range(0, 1) != 0 ? 'h1FE0 : 0);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [51:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (da[0]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_underflow addr=%h got=%h exp=none", addr, dr[0]);
        end else begin
          e = exp_q.pop_front();
          for (int d = 0; d < 4; d++) begin
            if (e[d*9+8]) begin
              n_vec++;
              if (dr[d] !== e[d*9 +: 8]) begin
                n_err++;
                $display("FAIL data_r dut%0d addr=%h got=%h exp=%h", d, e[51:36], dr[d], e[d*9 +: 8]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int a;
    int v;
    model_reset();
    do_reset('h4000, 1'b0, 0);
    do_reset('h0000, 1'b0, 0);
    // power-on state
    do_read('h4000);
    do_read('hA000);
    // rom_bank 0 remap (MBC1) and bank 5
    do_write('h2000, 'h00);
    do_read('h4000);
    do_write('h2000, 'h05);
    do_read('h4123);
    // MBC1 upper bank bits and mode 1
    do_write('h4000, 'h01);
    do_write('h6000, 'h01);
    do_write('h2000, 'h02);
    do_read('h0000);
    do_read('h4000);
    // external RAM enable, bank switch, disable
    do_write('h0000, 'h0A);
    do_write('h4000, 'h03);
    do_write('hA010, 'h5A);
    do_read('hA010);
    do_write('h4000, 'h00);
    do_write('hA010, 'h33);
    do_read('hA010);
    do_write('h4000, 'h03);
    do_read('hA010);
    do_write('h0000, 'h00);
    do_read('hA010);
    // MBC5 bit 8 of rom_bank, masked for small ROMs
    do_write('h2000, 'h00);
    do_write('h3000, 'h01);
    do_read('h4000);
    do_read('h7FFF);
    // reset mid-sequence, reset colliding with a write
    do_write('h2000, 'h07);
    do_write('h0000, 'h0A);
    do_reset('h2000, 1'b1, 'h09);
    do_read('h4000);
    do_read('hA000);
    do_read('hBFFF);
    do_read('hC000);
    do_read('h9FFF);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(0, 'hFFFF), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      end else if (r < 40) begin
        v = ($urandom_range(0, 3) == 0) ? 'h0A : $urandom_range(0, 255);
        case ($urandom_range(0, 3))
          0: a = $urandom_range(0, 'h7FFF);
          1: a = rand_ram_addr();
          2: a = rand_ram_addr();
          default: a = $urandom_range(0, 'hFFFF);
        endcase
        do_write(a, v);
      end else begin
        case ($urandom_range(0, 3))
          0: a = $urandom_range(0, 'h3FFF);
          1: a = $urandom_range('h4000, 'h7FFF);
          2: a = rand_ram_addr();
          default: a = $urandom_range(0, 'hFFFF);
        endcase
        do_read(a);
      end
    end
    do_read('hC000);
    do_read('hC000);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
